// File: rtl/fifo_pkg.sv
// Shared FIFO sizing and pointer/count types for the pointer controller and flag generators.
// No logic; no latency; no backpressure.
package fifo_pkg;
  localparam int SIZE  = 4;
  localparam int DEPTH = 1 << SIZE;

  typedef logic [SIZE:0] ptr_t;
  typedef logic [SIZE:0] cnt_t;
endpackage

// File: rtl/ptr_counter.sv
// Enabled wrap-around incrementer; ptr_nxt exposes the value ptr takes on the next edge.
// Latency: 1 cycle for ptr, 0 for ptr_nxt. No backpressure; inc is acted on unconditionally.
module ptr_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr,
  output logic [W-1:0] ptr_nxt
);

  assign ptr_nxt = inc ? ptr + W'(1) : ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/occupancy controller: RAM addresses, registered full/empty/count, sticky errors.
// Latency: 1 cycle for state and flags, 0 for wr_ok/rd_ok. No stall: requests against full/empty are dropped and flagged.
module fifo_ptr_ctrl #(
  parameter int SIZE = fifo_pkg::SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_en,
  input  logic            r_en,
  input  logic            err_clr,
  output logic [SIZE-1:0] w_pointer,
  output logic [SIZE-1:0] r_pointer,
  output logic            wr_ok,
  output logic            rd_ok,
  output logic            full,
  output logic            empty,
  output logic [SIZE:0]   count,
  output logic            overflow,
  output logic            underflow
);

  logic [SIZE:0] wp, rp, wp_nxt, rp_nxt;
  logic          full_nxt, empty_nxt;

  assign wr_ok = w_en & ~full;
  assign rd_ok = r_en & ~empty;

  ptr_counter #(.W(SIZE + 1)) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .inc     (wr_ok),
    .ptr     (wp),
    .ptr_nxt (wp_nxt)
  );

  ptr_counter #(.W(SIZE + 1)) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .inc     (rd_ok),
    .ptr     (rp),
    .ptr_nxt (rp_nxt)
  );

  assign w_pointer = wp[SIZE-1:0];
  assign r_pointer = rp[SIZE-1:0];

  // Flags come from the next-state pointers so they track accepted ops with no extra lag.
  assign empty_nxt = (wp_nxt == rp_nxt);
  assign full_nxt  = (wp_nxt[SIZE] != rp_nxt[SIZE]) &&
                     (wp_nxt[SIZE-1:0] == rp_nxt[SIZE-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      empty <= 1'b1;
      count <= '0;
    end else begin
      full  <= full_nxt;
      empty <= empty_nxt;
      count <= count + {{SIZE{1'b0}}, wr_ok} - {{SIZE{1'b0}}, rd_ok};
    end
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_en & full)  | (overflow  & ~err_clr);
      underflow <= (r_en & empty) | (underflow & ~err_clr);
    end
  end

  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (rst)
    count == (wp - rp));

endmodule
